// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: StackOp encodings issued by the decoder
// and the default datapath word width.
package cpu_defs;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    STACK_NONE = 2'b00,
    STACK_RSVD = 2'b01,
    STACK_PUSH = 2'b10,
    STACK_POP  = 2'b11
  } stack_op_e;

endpackage : cpu_defs

// File: rtl/stack_unit_regfile.sv
// Stack storage: DEPTH x WIDTH array with one synchronous write port and one
// asynchronous read port, so the top of stack is visible in the same cycle.
module stack_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; readers must qualify it with the
  // pointer, and leaving it unreset keeps it mappable onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : stack_regfile

// File: rtl/stack_unit.sv
// Hardware LIFO beside the register file: pushes Rt data, presents the top of
// stack combinationally for same-cycle write-back, and tracks sticky errors.
module stack_unit
  import cpu_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       StackOp,
  input  logic             Stall,
  input  logic [WIDTH-1:0] PushData,
  output logic [WIDTH-1:0] PopData,
  output logic [PTR_W-1:0] Depth,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow,
  input  logic             ErrClr
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             push_en, pop_en;
  logic             full, empty;
  logic             mem_we;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  assign full  = (sp_q == PTR_W'(DEPTH));
  assign empty = (sp_q == '0);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    push_en     = (StackOp == STACK_PUSH) && !Stall;
    pop_en      = (StackOp == STACK_POP) && !Stall;
    mem_we      = 1'b0;
    sp_d        = sp_q;
    overflow_d  = ErrClr ? 1'b0 : overflow_q;
    underflow_d = ErrClr ? 1'b0 : underflow_q;

    if (push_en) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        sp_d   = sp_q + PTR_W'(1);
      end
    end else if (pop_en) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        sp_d = sp_q - PTR_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // When full, the low pointer bits are zero and the subtraction wraps to the
  // last slot, which is exactly the top entry.
  assign rd_addr = sp_q[AW-1:0] - AW'(1);

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sp_q[AW-1:0]),
    .wdata (PushData),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign PopData   = empty ? '0 : rd_data;
  assign Depth     = sp_q;
  assign Full      = full;
  assign Empty     = empty;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

endmodule : stack_unit

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO that executes the StackOp field issued by the instruction decoder for push and pop.
- Sits beside the register file in the single-cycle datapath.
- Push: the Rt operand value is written at the clock edge.
- Pop: top-of-stack is presented combinationally, so write-back can route it to Rd through the MemToReg path in the same cycle. The pointer then retires the entry at the clock edge.
- Reports full/empty state and sticky overflow/underflow errors to the CPU status logic.

Parameters:
- WIDTH, 32, data word width (matches the register file).
- DEPTH, 16, number of stack entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer/occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StackOp  input  2  from decoder: 00 none, 10 push, 11 pop, 01 reserved (treated as none).
- Stall  input  1  pipeline hold; when 1, no stack state changes.
- PushData  input  WIDTH  value to push (Rt read data).
- PopData  output  WIDTH  current top-of-stack, combinational.
- Depth  output  PTR_W  current occupancy, 0..DEPTH.
- Full  output  1  Depth == DEPTH.
- Empty  output  1  Depth == 0.
- Overflow  output  1  sticky: a push was attempted while full.
- Underflow  output  1  sticky: a pop was attempted while empty.
- ErrClr  input  1  synchronous clear of the Overflow and Underflow flags.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sp=0, Overflow=0, Underflow=0.
  - Outputs: Depth=0, Empty=1, Full=0, PopData=0.
  - Storage contents are not reset.
  - Reset mid-operation: any push or pop in that cycle is lost; no partial update.
- Effective op per cycle: push_en = (StackOp==10) & ~Stall; pop_en = (StackOp==11) & ~Stall. The two are mutually exclusive by encoding.
- Push, not full:
  - mem[sp] <= PushData; sp <= sp+1.
  - Visible on PopData and Depth the next cycle (latency 1).
- Push when full:
  - Storage and sp unchanged.
  - Overflow <= 1 at the edge.
- Pop, not empty:
  - PopData = mem[sp-1] combinationally during the pop cycle.
  - sp <= sp-1 at the edge.
- Pop when empty:
  - PopData = 0; sp unchanged.
  - Underflow <= 1 at the edge.
- PopData is always mem[sp-1] when Depth>0, and 0 when empty. It is independent of StackOp, so top-of-stack can be peeked.
- Stall=1: sp, storage and the sticky flags are unchanged. ErrClr is still honoured.
- ErrClr=1 clears both sticky flags at the edge. If an error event occurs in the same cycle, the error set wins and the flag remains 1.
- sp never wraps: it saturates at 0 and at DEPTH by the rules above.
- Pointer arithmetic is PTR_W wide; the memory index is sp[PTR_W-2:0].
- Full and Empty are decoded combinationally from sp.
- Simultaneous push+pop is impossible by encoding.
- Back-to-back push then pop returns the just-pushed value.
- Alternating push/pop at full depth behaves normally: a pop from full is legal.
- No X propagation: PopData is driven to 0 when empty even though storage is unreset.

Decomposition:
- Shared package (cpu_defs):
  - StackOp encodings: STACK_NONE=2'b00, STACK_RSVD=2'b01, STACK_PUSH=2'b10, STACK_POP=2'b11.
  - Default WIDTH constant.
- Sub-module stack_regfile:
  - DEPTH x WIDTH array, one synchronous write port, one asynchronous read port, no reset.
  - stack_unit owns pointer, flags and gating.

Test Plan:
1. Reset then idle → Depth=0, Empty=1, PopData=0, flags 0. Push 0xDEADBEEF → next cycle Depth=1, PopData=0xDEADBEEF, Empty=0.
2. Push 1..16 (DEPTH=16) → Full=1, Depth=16. 17th push of 0x99 → Overflow=1, Depth=16, PopData=16. Then 16 pops observe PopData 16,15,…,1 in pop cycles, ending with Empty=1.
3. Pop on empty → PopData=0 that cycle, Underflow=1 next cycle, Depth stays 0. ErrClr=1 → Underflow=0. ErrClr together with another empty pop → Underflow stays 1.
4. Push 0xA, assert Stall with StackOp=pop for 3 cycles → Depth=1, PopData=0xA throughout. Release Stall with pop → PopData=0xA that cycle, Depth=0 after.
5. Push 5 values, assert rst_n=0 asynchronously mid-cycle during a push → Depth=0, Empty=1, PopData=0 immediately, with no clock edge needed.
6. StackOp=01 with PushData=0x1234 → no state change, Depth and flags unchanged.
